// File: rtl/fetch_sequencer_pkg.sv
// Package fetch_pkg: shared types and defaults for the fetch-stage sequencer.
//  - fetch_state_e : FSM encoding (IDLE=0, RUN=1, FREEZE=2, REDIRECT=3), exported on state_o
//  - INSN_BYTES_DEF: default sequential PC increment
//  - ADDR_W_DEF    : default PC width
package fetch_pkg;

    localparam int INSN_BYTES_DEF = 4;
    localparam int ADDR_W_DEF     = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FREEZE   = 2'd2,
        ST_REDIRECT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Interface fetch_sequencer_if: PC-register / IF-ID control bundle between the
// fetch sequencer and the datapath.
//  Datapath -> sequencer: pc_i, imem_stall_i, dmem_stall_i, hazard_stall_i,
//                         branch_taken_i, branch_target_i, jump_i, jump_target_i
//  Sequencer -> datapath: pc_next_o, pc_enable_o, pc_stall_o, ifid_write_o, ifid_flush_o
//  Modports: master = sequencer side, slave = datapath side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              imem_stall_i;
    logic              dmem_stall_i;
    logic              hazard_stall_i;
    logic              branch_taken_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_target_i;

    logic [ADDR_W-1:0] pc_next_o;
    logic              pc_enable_o;
    logic              pc_stall_o;
    logic              ifid_write_o;
    logic              ifid_flush_o;

    modport master (
        input  pc_i, imem_stall_i, dmem_stall_i, hazard_stall_i,
               branch_taken_i, branch_target_i, jump_i, jump_target_i,
        output pc_next_o, pc_enable_o, pc_stall_o, ifid_write_o, ifid_flush_o
    );

    modport slave (
        output pc_i, imem_stall_i, dmem_stall_i, hazard_stall_i,
               branch_taken_i, branch_target_i, jump_i, jump_target_i,
        input  pc_next_o, pc_enable_o, pc_stall_o, ifid_write_o, ifid_flush_o
    );
endinterface

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: two saturating event counters for the fetch sequencer.
//  clk_i, rst_i (async, active-low)
//  stall_inc      in  : one stall (memory freeze or hazard) cycle observed
//  redirect_inc   in  : one redirect applied to the PC
//  stall_cycles   out : saturating count of stall cycles
//  redirect_cnt   out : saturating count of applied redirects
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters #(
    parameter int PERF_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_inc,
    input  logic              redirect_inc,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] redirect_cnt
);

    logic [PERF_W-1:0] stall_cnt_r;
    logic [PERF_W-1:0] redir_cnt_r;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= '0;
            redir_cnt_r <= '0;
        end else begin
            if (stall_inc && (stall_cnt_r != '1)) begin
                stall_cnt_r <= stall_cnt_r + PERF_W'(1);
            end
            if (redirect_inc && (redir_cnt_r != '1)) begin
                redir_cnt_r <= redir_cnt_r + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign redirect_cnt = redir_cnt_r;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage controller. Merges run/start, memory-stall freeze,
// load-use hazard stall and branch/jump redirects into PC-register and IF/ID controls.
// A redirect seen while memory is stalled is held in a pending register and applied
// through the one-cycle REDIRECT state once the stall clears.
//  clk_i, rst_i (async, active-low), start_i (low forces IDLE)
//  bus            : fetch_sequencer_if.master (PC/IF-ID controls and their inputs)
//  state_o        : FSM state for debug
//  stall_cycles_o : stall cycle count, redirect_cnt_o : applied redirect count
// Optional feature macro: FETCH_PERF_EN builds the counters; otherwise both read 0.
// Outputs are combinational from state and inputs, so pc_i feeds pc_next_o directly.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INSN_BYTES = INSN_BYTES_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PERF_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    fetch_sequencer_if.master    bus,
    output logic [1:0]           state_o,
    output logic [PERF_W-1:0]    stall_cycles_o,
    output logic [PERF_W-1:0]    redirect_cnt_o
);

    fetch_state_e      state_r, state_s;
    logic              pend_valid_r, pend_valid_s;
    logic [ADDR_W-1:0] pend_target_r, pend_target_s;

    logic              memstall_s;
    logic              redirect_s;
    logic [ADDR_W-1:0] redir_target_s;

    logic [ADDR_W-1:0] pc_next_s;
    logic              pc_enable_s;
    logic              pc_stall_s;
    logic              ifid_write_s;
    logic              ifid_flush_s;
    logic              stall_ev_s;
    logic              redir_ev_s;

    assign memstall_s     = bus.imem_stall_i | bus.dmem_stall_i;
    assign redirect_s     = bus.branch_taken_i | bus.jump_i;
    // Branch takes precedence over jump when both resolve in the same cycle.
    assign redir_target_s = bus.branch_taken_i ? bus.branch_target_i : bus.jump_target_i;

    // Next-state, pending-redirect update and output decode.
    always_comb begin
        state_s       = state_r;
        pend_valid_s  = pend_valid_r;
        pend_target_s = pend_target_r;
        pc_next_s     = RESET_PC;
        pc_enable_s   = 1'b0;
        pc_stall_s    = 1'b0;
        ifid_write_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        stall_ev_s    = 1'b0;
        redir_ev_s    = 1'b0;
        if (!start_i) begin
            state_s      = ST_IDLE;
            pend_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_RUN;
                end
                ST_RUN: begin
                    if (memstall_s) begin
                        pc_next_s  = bus.pc_i;
                        pc_stall_s = 1'b1;
                        stall_ev_s = 1'b1;
                        state_s    = ST_FREEZE;
                        if (redirect_s) begin
                            pend_valid_s  = 1'b1;
                            pend_target_s = redir_target_s;
                        end else begin
                            pend_valid_s  = pend_valid_r;
                        end
                    end else if (bus.hazard_stall_i) begin
                        // The ID instruction is re-presented next cycle, so any
                        // redirect it carries is ignored now and seen again later.
                        pc_next_s  = bus.pc_i;
                        stall_ev_s = 1'b1;
                    end else if (redirect_s) begin
                        pc_next_s    = redir_target_s;
                        pc_enable_s  = 1'b1;
                        ifid_write_s = 1'b1;
                        ifid_flush_s = 1'b1;
                        redir_ev_s   = 1'b1;
                    end else begin
                        pc_next_s    = bus.pc_i + ADDR_W'(INSN_BYTES);
                        pc_enable_s  = 1'b1;
                        ifid_write_s = 1'b1;
                    end
                end
                ST_FREEZE: begin
                    pc_next_s  = bus.pc_i;
                    pc_stall_s = memstall_s;
                    stall_ev_s = memstall_s | bus.hazard_stall_i;
                    // Latest redirect wins while frozen.
                    if (redirect_s) begin
                        pend_valid_s  = 1'b1;
                        pend_target_s = redir_target_s;
                    end else begin
                        pend_valid_s  = pend_valid_r;
                    end
                    if (!memstall_s) begin
                        state_s = (pend_valid_r || redirect_s) ? ST_REDIRECT : ST_RUN;
                    end else begin
                        state_s = ST_FREEZE;
                    end
                end
                ST_REDIRECT: begin
                    pc_next_s = pend_target_r;
                    if (memstall_s) begin
                        pc_stall_s = 1'b1;
                    end else begin
                        pc_enable_s  = 1'b1;
                        ifid_flush_s = 1'b1;
                        redir_ev_s   = 1'b1;
                        pend_valid_s = 1'b0;
                        state_s      = ST_RUN;
                    end
                end
                default: begin
                    state_s      = ST_IDLE;
                    pend_valid_s = 1'b0;
                end
            endcase
        end
    end

    // FSM state and pending-redirect register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r       <= ST_IDLE;
            pend_valid_r  <= 1'b0;
            pend_target_r <= '0;
        end else begin
            state_r       <= state_s;
            pend_valid_r  <= pend_valid_s;
            pend_target_r <= pend_target_s;
        end
    end

    assign bus.pc_next_o    = pc_next_s;
    assign bus.pc_enable_o  = pc_enable_s;
    assign bus.pc_stall_o   = pc_stall_s;
    assign bus.ifid_write_o = ifid_write_s;
    assign bus.ifid_flush_o = ifid_flush_s;
    assign state_o          = state_r;

`ifdef FETCH_PERF_EN
    fetch_perf_counters #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_inc    (stall_ev_s),
        .redirect_inc (redir_ev_s),
        .stall_cycles (stall_cycles_o),
        .redirect_cnt (redirect_cnt_o)
    );
`else
    logic unused_perf_s;
    assign unused_perf_s  = stall_ev_s ^ redir_ev_s;
    assign stall_cycles_o = '0;
    assign redirect_cnt_o = '0;
`endif

endmodule
